// File: rtl/htif_mailbox_if.sv
// htif_mailbox_if: core-side request/response bus of the HTIF mailbox.
// The core drives through the master modport, the mailbox through slave.
`timescale 1ns/1ps
interface htif_mailbox_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [3:0]  req_addr;
   logic [63:0] req_wdata;
   logic [7:0]  req_wstrb;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/htif_mailbox.sv
// htif_mailbox: tohost/fromhost mailbox between the core and the simulation
// harness. tohost holds a completion/syscall code until the harness acks it;
// fromhost carries harness-injected words to the core.
// Optional watchdog: define HTIF_MAILBOX_WDOG_EN to build the unacked-tohost
// counter and wdog_irq; otherwise wdog_irq is tied low.
`timescale 1ns/1ps
module htif_mailbox #(
   parameter int unsigned TIMEOUT_CYCLES = 32'd50000
) (
   input  logic         clock,
   input  logic         reset,
   htif_mailbox_if.slave bus,
   output logic [63:0]  tohost,
   input  logic         tohost_ack,
   input  logic         fromhost_valid,
   input  logic [63:0]  fromhost_data,
   output logic         wdog_irq
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_t;

   // Byte-enable merge of new write data over an existing register value.
   function automatic logic [63:0] merge_bytes(input logic [63:0] old_val,
                                               input logic [63:0] wdata,
                                               input logic [7:0]  wstrb);
      logic [63:0] res;
      res = old_val;
      for (int i = 0; i < 8; i++) begin
         res[8*i +: 8] = wstrb[i] ? wdata[8*i +: 8] : old_val[8*i +: 8];
      end
      return res;
   endfunction

   state_t      state_r;
   state_t      state_next_s;
   logic [63:0] tohost_r;
   logic [63:0] tohost_next_s;
   logic [63:0] fromhost_r;
   logic [63:0] fromhost_next_s;
   logic [63:0] rdata_r;
   logic        err_r;
   logic [63:0] rdata_sel_s;
   logic        hit_to_s;
   logic        hit_from_s;
   logic        unmapped_s;
   logic        req_ready_s;
   logic        resp_valid_s;
   logic        accept_s;
   logic        wr_to_s;
   logic        wr_from_s;

   // Address decode of the incoming request.
   always_comb begin
      hit_to_s   = (bus.req_addr == 4'h0);
      hit_from_s = (bus.req_addr == 4'h8);
      unmapped_s = !(hit_to_s || hit_from_s);
   end

   // FSM outputs: ready in IDLE unless a tohost write would overwrite a pending code.
   always_comb begin
      req_ready_s  = 1'b0;
      resp_valid_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.req_write && hit_to_s && (tohost_r != 64'd0)) begin
               req_ready_s = 1'b0;
            end else begin
               req_ready_s = 1'b1;
            end
         end
         RESP: begin
            resp_valid_s = 1'b1;
         end
         default: begin
            req_ready_s  = 1'b0;
            resp_valid_s = 1'b0;
         end
      endcase
      accept_s  = bus.req_valid && req_ready_s;
      wr_to_s   = accept_s && bus.req_write && hit_to_s;
      wr_from_s = accept_s && bus.req_write && hit_from_s;
   end

   // FSM next state: one accepted request, then hold its response until taken.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_next_s = RESP;
            end else begin
               state_next_s = IDLE;
            end
         end
         RESP: begin
            if (bus.resp_ready) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = RESP;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Read data selected at accept time; writes and unmapped reads return 0.
   always_comb begin
      rdata_sel_s = 64'd0;
      if (!bus.req_write && hit_to_s) begin
         rdata_sel_s = tohost_r;
      end else if (!bus.req_write && hit_from_s) begin
         rdata_sel_s = fromhost_r;
      end else begin
         rdata_sel_s = 64'd0;
      end
   end

   // Response payload register, captured on accept and cleared when consumed.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rdata_r <= 64'd0;
         err_r   <= 1'b0;
      end else if (accept_s) begin
         rdata_r <= rdata_sel_s;
         err_r   <= unmapped_s;
      end else if (resp_valid_s && bus.resp_ready) begin
         rdata_r <= 64'd0;
         err_r   <= 1'b0;
      end
   end

   // tohost next value: an accepted write beats a same-cycle ack.
   always_comb begin
      tohost_next_s = tohost_r;
      if (wr_to_s) begin
         tohost_next_s = merge_bytes(tohost_r, bus.req_wdata, bus.req_wstrb);
      end else if (tohost_ack) begin
         tohost_next_s = 64'd0;
      end else begin
         tohost_next_s = tohost_r;
      end
   end

   // fromhost next value: a harness load beats a same-cycle core write.
   always_comb begin
      fromhost_next_s = fromhost_r;
      if (fromhost_valid) begin
         fromhost_next_s = fromhost_data;
      end else if (wr_from_s) begin
         fromhost_next_s = merge_bytes(fromhost_r, bus.req_wdata, bus.req_wstrb);
      end else begin
         fromhost_next_s = fromhost_r;
      end
   end

   // Mailbox registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tohost_r   <= 64'd0;
         fromhost_r <= 64'd0;
      end else begin
         tohost_r   <= tohost_next_s;
         fromhost_r <= fromhost_next_s;
      end
   end

`ifdef HTIF_MAILBOX_WDOG_EN
   localparam logic [31:0] TIMEOUT_L = 32'(TIMEOUT_CYCLES);

   logic [31:0] wdog_cnt_r;
   logic [31:0] wdog_cnt_next_s;
   logic        wdog_irq_r;

   // Watchdog count: runs while tohost is pending, restarts on ack or new code, saturates.
   always_comb begin
      wdog_cnt_next_s = wdog_cnt_r;
      if ((tohost_r == 64'd0) || tohost_ack || wr_to_s) begin
         wdog_cnt_next_s = 32'd0;
      end else if (wdog_cnt_r >= TIMEOUT_L) begin
         wdog_cnt_next_s = TIMEOUT_L;
      end else begin
         wdog_cnt_next_s = wdog_cnt_r + 32'd1;
      end
   end

   // Watchdog counter and sticky interrupt, cleared only by ack or reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wdog_cnt_r <= 32'd0;
         wdog_irq_r <= 1'b0;
      end else begin
         wdog_cnt_r <= wdog_cnt_next_s;
         if (tohost_ack) begin
            wdog_irq_r <= 1'b0;
         end else if (wdog_cnt_next_s == TIMEOUT_L) begin
            wdog_irq_r <= 1'b1;
         end
      end
   end

   assign wdog_irq = wdog_irq_r;
`else
   logic unused_timeout_s;
   assign unused_timeout_s = ^TIMEOUT_CYCLES;
   assign wdog_irq = 1'b0;
`endif

   assign bus.req_ready  = req_ready_s;
   assign bus.resp_valid = resp_valid_s;
   assign bus.resp_rdata = rdata_r;
   assign bus.resp_err   = err_r;
   assign tohost         = tohost_r;

endmodule

// File: tb/tb_htif_mailbox.sv
// tb_htif_mailbox: scenario tasks drive the core bus and harness pins; every
// accepted request pushes its expected response, which a monitor pops and
// compares when the response handshake happens.
`timescale 1ns/1ps
module tb_htif_mailbox;
   localparam int unsigned TMO = 16;

   logic        clock;
   logic        reset;
   logic [63:0] tohost;
   logic        tohost_ack;
   logic        fromhost_valid;
   logic [63:0] fromhost_data;
   logic        wdog_irq;

   htif_mailbox_if bus();

   htif_mailbox #(.TIMEOUT_CYCLES(TMO)) dut (
      .clock          (clock),
      .reset          (reset),
      .bus            (bus),
      .tohost         (tohost),
      .tohost_ack     (tohost_ack),
      .fromhost_valid (fromhost_valid),
      .fromhost_data  (fromhost_data),
      .wdog_irq       (wdog_irq)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic [63:0] rdata;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks;
   int   n_pass;
   int   resp_count;
   time  last_accept;

   // Pops the expected response whenever the core takes one.
   task automatic monitor_loop();
      exp_t e;
      forever begin
         @(negedge clock);
         if (reset === 1'b0 && bus.resp_valid === 1'b1 && bus.resp_ready === 1'b1) begin
            resp_count++;
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL resp_unexpected: got rdata=%0h err=%b, expected no response", bus.resp_rdata, bus.resp_err);
            end else begin
               e = exp_q.pop_front();
               if (bus.resp_rdata !== e.rdata || bus.resp_err !== e.err)
                  $display("FAIL resp_data: got rdata=%0h err=%b, expected rdata=%0h err=%b", bus.resp_rdata, bus.resp_err, e.rdata, e.err);
               else
                  n_pass++;
            end
         end
      end
   endtask

   // Issues one request (caller sits at a negedge); returns at the negedge after accept.
   task automatic send(input logic w, input logic [3:0] a, input logic [63:0] d, input logic [7:0] s,
                       input logic [63:0] er, input logic ee, output int stall);
      exp_t e;
      bus.req_valid = 1'b1;
      bus.req_write = w;
      bus.req_addr  = a;
      bus.req_wdata = d;
      bus.req_wstrb = s;
      #1;
      stall = 0;
      while (bus.req_ready !== 1'b1 && stall < 200) begin
         @(negedge clock); #1;
         stall++;
      end
      if (bus.req_ready !== 1'b1) begin
         n_checks++;
         $display("FAIL req_accept_timeout: req_ready=%b after %0d cycles, expected 1", bus.req_ready, stall);
         bus.req_valid = 1'b0;
      end else begin
         e.rdata = er;
         e.err   = ee;
         exp_q.push_back(e);
         @(posedge clock);
         last_accept = $time;
         @(negedge clock);
         bus.req_valid = 1'b0;
      end
   endtask

   // Waits (bounded) until every expected response has been consumed.
   task automatic drain();
      int k;
      k = 0;
      while ((exp_q.size() != 0 || bus.resp_valid === 1'b1) && k < 100) begin
         @(negedge clock);
         k++;
      end
      if (k >= 100) begin
         n_checks++;
         $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
      end
   endtask

   task automatic ack_pulse();
      tohost_ack = 1'b1;
      @(negedge clock);
      tohost_ack = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL rst_req_ready: got %b, expected 1", bus.req_ready); else n_pass++;
      n_checks++; if (bus.resp_valid !== 1'b0) $display("FAIL rst_resp_valid: got %b, expected 0", bus.resp_valid); else n_pass++;
      n_checks++; if (bus.resp_rdata !== 64'd0) $display("FAIL rst_resp_rdata: got %0h, expected 0", bus.resp_rdata); else n_pass++;
      n_checks++; if (bus.resp_err !== 1'b0) $display("FAIL rst_resp_err: got %b, expected 0", bus.resp_err); else n_pass++;
      n_checks++; if (tohost !== 64'd0) $display("FAIL rst_tohost: got %0h, expected 0", tohost); else n_pass++;
      n_checks++; if (wdog_irq !== 1'b0) $display("FAIL rst_wdog_irq: got %b, expected 0", wdog_irq); else n_pass++;
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_tohost_write();
      int st;
      int rc0;
      rc0 = resp_count;
      send(1'b1, 4'h0, 64'h1, 8'hFF, 64'd0, 1'b0, st);
      n_checks++; if (tohost !== 64'h1) $display("FAIL wr_tohost_n1: got %0h, expected 1", tohost); else n_pass++;
      n_checks++; if (bus.resp_valid !== 1'b1) $display("FAIL wr_resp_valid_n1: got %b, expected 1", bus.resp_valid); else n_pass++;
      drain();
      n_checks++; if (resp_count - rc0 !== 1) $display("FAIL wr_resp_count: got %0d, expected 1", resp_count - rc0); else n_pass++;
      ack_pulse();
      n_checks++; if (tohost !== 64'd0) $display("FAIL ack_clear: got %0h, expected 0", tohost); else n_pass++;
   endtask

   task automatic test_tohost_stall();
      int st;
      int ready_seen;
      send(1'b1, 4'h0, 64'h5, 8'hFF, 64'd0, 1'b0, st);
      drain();
      n_checks++; if (tohost !== 64'h5) $display("FAIL stall_pre_tohost: got %0h, expected 5", tohost); else n_pass++;
      ready_seen = 0;
      fork
         send(1'b1, 4'h0, 64'h7, 8'hFF, 64'd0, 1'b0, st);
         begin
            for (int i = 0; i < 10; i++) begin
               @(negedge clock); #1;
               if (bus.req_ready === 1'b1) ready_seen++;
            end
            tohost_ack = 1'b1;
            @(negedge clock); #1;
            tohost_ack = 1'b0;
            n_checks++; if (tohost !== 64'd0) $display("FAIL stall_ack_clear: got %0h, expected 0", tohost); else n_pass++;
         end
      join
      n_checks++; if (ready_seen !== 0) $display("FAIL stall_ready_low: got ready high in %0d cycles, expected 0", ready_seen); else n_pass++;
      n_checks++; if (st !== 11) $display("FAIL stall_cycles: got %0d, expected 11", st); else n_pass++;
      n_checks++; if (tohost !== 64'h7) $display("FAIL stall_tohost_new: got %0h, expected 7", tohost); else n_pass++;
      drain();
      ack_pulse();
   endtask

   task automatic test_ack_write_same_cycle();
      int st;
      tohost_ack = 1'b1;
      send(1'b1, 4'h0, 64'h9, 8'hFF, 64'd0, 1'b0, st);
      tohost_ack = 1'b0;
      n_checks++; if (tohost !== 64'h9) $display("FAIL ack_vs_write: got %0h, expected 9", tohost); else n_pass++;
      drain();
      ack_pulse();
   endtask

   task automatic test_fromhost();
      int st;
      fromhost_valid = 1'b1;
      fromhost_data  = 64'hDEAD;
      send(1'b1, 4'h8, 64'h0, 8'hFF, 64'd0, 1'b0, st);
      fromhost_valid = 1'b0;
      send(1'b0, 4'h8, 64'h0, 8'h00, 64'hDEAD, 1'b0, st);
      send(1'b1, 4'h8, 64'h1122, 8'h01, 64'd0, 1'b0, st);
      send(1'b0, 4'h8, 64'h0, 8'h00, 64'hDE22, 1'b0, st);
      send(1'b1, 4'h8, 64'h0, 8'hFF, 64'd0, 1'b0, st);
      send(1'b0, 4'h8, 64'h0, 8'h00, 64'd0, 1'b0, st);
      send(1'b1, 4'h8, 64'h55, 8'hFF, 64'd0, 1'b0, st);
      drain();
   endtask

   task automatic test_unmapped();
      int st;
      int held_bad;
      bus.resp_ready = 1'b0;
      send(1'b0, 4'h4, 64'h0, 8'h00, 64'd0, 1'b1, st);
      n_checks++; if (bus.resp_err !== 1'b1 || bus.resp_rdata !== 64'd0)
         $display("FAIL unmapped_rd: got rdata=%0h err=%b, expected rdata=0 err=1", bus.resp_rdata, bus.resp_err); else n_pass++;
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_addr  = 4'h0;
      held_bad = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1 || bus.resp_rdata !== 64'd0 || bus.req_ready !== 1'b0)
            held_bad++;
      end
      n_checks++; if (held_bad !== 0) $display("FAIL resp_hold: got %0d unstable cycles, expected 0", held_bad); else n_pass++;
      bus.req_valid = 1'b0;
      @(posedge clock); #1;
      bus.resp_ready = 1'b1;
      @(negedge clock);
      drain();
      send(1'b1, 4'hC, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'd0, 1'b1, st);
      drain();
      n_checks++; if (tohost !== 64'd0) $display("FAIL unmapped_wr_tohost: got %0h, expected 0", tohost); else n_pass++;
      send(1'b0, 4'h8, 64'h0, 8'h00, 64'h55, 1'b0, st);
      drain();
   endtask

   task automatic test_back_to_back();
      int  st;
      time t1;
      send(1'b0, 4'h0, 64'h0, 8'h00, 64'd0, 1'b0, st);
      t1 = last_accept;
      send(1'b0, 4'h8, 64'h0, 8'h00, 64'h55, 1'b0, st);
      n_checks++; if (last_accept - t1 !== 64'd20) $display("FAIL b2b_spacing: got %0t, expected 20", last_accept - t1); else n_pass++;
      drain();
   endtask

   task automatic test_reset_mid();
      int st;
      bus.resp_ready = 1'b0;
      send(1'b1, 4'h0, 64'hFF00, 8'h02, 64'd0, 1'b0, st);
      n_checks++; if (tohost !== 64'hFF00) $display("FAIL strobe_merge: got %0h, expected ff00", tohost); else n_pass++;
      n_checks++; if (bus.resp_valid !== 1'b1) $display("FAIL mid_resp_valid: got %b, expected 1", bus.resp_valid); else n_pass++;
      #2;
      reset = 1'b1;
      #1;
      n_checks++; if (bus.resp_valid !== 1'b0 || bus.resp_rdata !== 64'd0 || bus.resp_err !== 1'b0)
         $display("FAIL async_rst_resp: got valid=%b rdata=%0h err=%b, expected 0/0/0", bus.resp_valid, bus.resp_rdata, bus.resp_err); else n_pass++;
      n_checks++; if (tohost !== 64'd0) $display("FAIL async_rst_tohost: got %0h, expected 0", tohost); else n_pass++;
      n_checks++; if (bus.req_ready !== 1'b1 || wdog_irq !== 1'b0)
         $display("FAIL async_rst_ready_irq: got ready=%b irq=%b, expected 1/0", bus.req_ready, wdog_irq); else n_pass++;
      exp_q.delete();
      @(negedge clock);
      reset = 1'b0;
      bus.resp_ready = 1'b1;
      @(negedge clock);
      send(1'b0, 4'h8, 64'h0, 8'h00, 64'd0, 1'b0, st);
      drain();
   endtask

   task automatic test_wdog();
      int st;
      send(1'b1, 4'h0, 64'h3, 8'hFF, 64'd0, 1'b0, st);
`ifdef HTIF_MAILBOX_WDOG_EN
      repeat (15) @(negedge clock);
      n_checks++; if (wdog_irq !== 1'b0) $display("FAIL wdog_early: got %b, expected 0", wdog_irq); else n_pass++;
      @(negedge clock);
      n_checks++; if (wdog_irq !== 1'b1) $display("FAIL wdog_fire: got %b, expected 1", wdog_irq); else n_pass++;
      repeat (5) @(negedge clock);
      n_checks++; if (wdog_irq !== 1'b1) $display("FAIL wdog_sticky: got %b, expected 1", wdog_irq); else n_pass++;
      ack_pulse();
      n_checks++; if (wdog_irq !== 1'b0 || tohost !== 64'd0)
         $display("FAIL wdog_ack_clear: got irq=%b tohost=%0h, expected 0/0", wdog_irq, tohost); else n_pass++;
      repeat (3) @(negedge clock);
      n_checks++; if (wdog_irq !== 1'b0) $display("FAIL wdog_stays_clear: got %b, expected 0", wdog_irq); else n_pass++;
`else
      repeat (30) @(negedge clock);
      n_checks++; if (wdog_irq !== 1'b0) $display("FAIL wdog_disabled: got %b, expected 0", wdog_irq); else n_pass++;
      ack_pulse();
      n_checks++; if (tohost !== 64'd0) $display("FAIL wdog_off_ack: got %0h, expected 0", tohost); else n_pass++;
`endif
      drain();
   endtask

   initial begin
      n_checks       = 0;
      n_pass         = 0;
      resp_count     = 0;
      last_accept    = 0;
      reset          = 1'b1;
      tohost_ack     = 1'b0;
      fromhost_valid = 1'b0;
      fromhost_data  = 64'd0;
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_addr   = 4'h0;
      bus.req_wdata  = 64'd0;
      bus.req_wstrb  = 8'h00;
      bus.resp_ready = 1'b1;
      fork
         monitor_loop();
      join_none
      test_reset();
      test_tohost_write();
      test_tohost_stall();
      test_ack_write_same_cycle();
      test_fromhost();
      test_unmapped();
      test_back_to_back();
      test_reset_mid();
      test_wdog();
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL scoreboard_empty: got %0d pending, expected 0", exp_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/htif_mailbox.md
# htif_mailbox

SoC-side tohost/fromhost mailbox for the simulation harness. The core stores completion and syscall codes into `tohost` over a simple request/response port. The block holds the value stable for the testbench and clears it when the harness acknowledges. It also accepts harness-injected `fromhost` words for the core to read and clear, and optionally raises a watchdog interrupt if a pending `tohost` is never acknowledged.

## Interface
- `TIMEOUT_CYCLES`, default 50000: cycles a nonzero `tohost` may remain unacknowledged before `wdog_irq` fires (watchdog build only).
- `clock`  in  1  sole clock; all state is updated on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `req_valid`  in  1  core request valid.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  4  byte offset: 0x0 = tohost, 0x8 = fromhost; all other offsets are unmapped.
- `req_wdata`  in  64  write data.
- `req_wstrb`  in  8  byte enables; bit i enables `wdata[8i+7:8i]`.
- `resp_valid`  out  1  response valid.
- `resp_ready`  in  1  core accepts the response.
- `resp_rdata`  out  64  read data; 0 for writes.
- `resp_err`  out  1  access targeted an unmapped offset.
- `tohost`  out  64  current tohost register, driven to the harness.
- `tohost_ack`  in  1  harness pulse: clear tohost.
- `fromhost_valid`  in  1  harness load strobe.
- `fromhost_data`  in  64  value for the harness load.
- `wdog_irq`  out  1  sticky watchdog interrupt.

## Operation
- FSM states:
  - IDLE: accepts requests.
  - RESP: holds `resp_valid/resp_rdata/resp_err` stable until `resp_ready`, then returns to IDLE. No new request is accepted in RESP.
- `req_ready` is 1 in IDLE, except when the request is a write to 0x0 while `tohost != 0`. In that case the write stalls (ready = 0) until the register is cleared.
- tohost write:
  - Byte-masked merge of `req_wdata` into `tohost` on accept.
  - A write of all-zero data is legal and leaves `tohost` at 0.
- `tohost_ack`:
  - Clears `tohost` to 0 on the next edge.
  - Ack while `tohost == 0` has no effect.
  - Ack in the same cycle as an accepted tohost write: this cannot happen for a stalled write. If the register is already 0, the write is accepted and wins (the ack is dropped).
- fromhost:
  - Core write merges by strobe; software clears it by writing 0.
  - `fromhost_valid` loads `fromhost_data` whole.
  - If a harness load and a core write hit fromhost in the same cycle, the harness load wins.
- Reads:
  - 0x0 returns `tohost`; 0x8 returns `fromhost`, sampled at accept.
  - Unmapped read: rdata = 0, err = 1. Unmapped write: ignored, err = 1.
- Reset mid-transaction: the FSM returns to IDLE, and any pending response is lost without being presented.

## Timing
- Reset values: `req_ready` = 1 (for non-stalling requests), `resp_valid` = 0, `resp_rdata` = 0, `resp_err` = 0, `tohost` = 0, fromhost = 0, `wdog_irq` = 0, counter = 0.
- Latency: the request is accepted at edge N. `resp_valid` is high from N+1 until the edge at which `resp_ready` is sampled high.
- Back-to-back throughput: one request per 2 cycles when `resp_ready` is held at 1.
- Register side effects are visible on `tohost` the cycle after accept (N+1).
- `tohost` clears the cycle after the `tohost_ack` edge. A stalled write is accepted no earlier than the cycle after that.
- `req_ready` depends combinationally on `req_write/req_addr` and registered state only, never on `resp_ready`.

## Configuration
- `HTIF_MAILBOX_WDOG_EN` defined:
  - A 32-bit counter increments every cycle while `tohost != 0`.
  - It resets to 0 when `tohost` is 0 or when a new value is written.
  - It saturates at `TIMEOUT_CYCLES`.
  - `wdog_irq` sets when the count equals `TIMEOUT_CYCLES` and stays set until `tohost_ack` or `reset`.
- Not defined: no counter is built, and `wdog_irq` is tied to 0.

## Test plan
- Reset release, then write 0x1 to 0x0 with strobe 0xFF: `tohost` = 0x1 at N+1, one `resp_valid`, `resp_err` = 0.
- tohost = 0x5 pending, core writes 0x7, harness acks 10 cycles later: `req_ready` = 0 for those cycles; `tohost` = 0 after the ack, then 0x7 one cycle after accept.
- Harness loads 0xDEAD via `fromhost_valid` in the same cycle as a core write of 0 to 0x8: the subsequent read of 0x8 returns 0xDEAD.
- Read of 0x4 and write of 0xC: `rdata` = 0, `resp_err` = 1, no register changes. Hold `resp_ready` = 0 for 3 cycles: the response is held stable and no request is accepted.
- Write 0xFF00 with strobe 0x02 onto `tohost` = 0: `tohost` = 0xFF00. Assert `reset` while in RESP: all outputs return to reset values asynchronously.
- With `HTIF_MAILBOX_WDOG_EN` and `TIMEOUT_CYCLES` = 16: write 0x3 and never ack; `wdog_irq` rises 16 cycles after the write and stays high; an ack clears it. Without the macro, `wdog_irq` stays 0.
